// File: rtl/vmem_pkg.sv
// vmem_pkg: shared state type, default preload values and preload helper
// for the dual-port video memory.
package vmem_pkg;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    localparam logic [7:0] DEAD_DEF = 8'hFF;
    localparam logic [7:0] LIVE_DEF = 8'h00;

    // Wide enough for any practical DATA_W; callers cast down.
    localparam int VAL_W = 64;

    function automatic logic [VAL_W-1:0] preload_val(
        input int               addr,
        input int               dead_words,
        input logic [VAL_W-1:0] dead_val,
        input logic [VAL_W-1:0] live_val
    );
        return (addr < dead_words) ? dead_val : live_val;
    endfunction

endpackage

// File: rtl/vmem_bank.sv
// vmem_bank: one write port, two registered read ports, read-before-write.
// The array itself carries no reset; only the read registers do.
module vmem_bank #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking reads see the pre-write contents on a same-address hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (re_a) begin
                rdata_a <= mem[raddr_a];
            end
            if (re_b) begin
                rdata_b <= mem[raddr_b];
            end
        end
    end

endmodule

// File: rtl/vmem_dp.sv
// vmem_dp: dual-port video memory with counter-driven preload after reset.
// Define VMEM_DOUBLE_BUFFER_EN for two banks swapped by frame_swap.
module vmem_dp
    import vmem_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 5,
    parameter int                DEAD_WORDS = 16,
    parameter logic [DATA_W-1:0] DEAD_VAL   = DATA_W'(DEAD_DEF),
    parameter logic [DATA_W-1:0] LIVE_VAL   = DATA_W'(LIVE_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_req,
    output logic              init_busy,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              disp_re,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              frame_swap,
    output logic              front_bank
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              in_init, ready;
    logic              cpu_rd, disp_rd;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata, init_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (init_req) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign in_init   = (state_q == INIT);
    assign ready     = (state_q == READY);
    assign init_busy = in_init;

    // A simultaneous write drops the CPU read.
    assign cpu_rd  = ready & cpu_re & ~cpu_we;
    assign disp_rd = ready & disp_re;

    assign init_word = DATA_W'(preload_val(int'(cnt_q), DEAD_WORDS,
                                           VAL_W'(DEAD_VAL),
                                           VAL_W'(LIVE_VAL)));
    assign waddr = in_init ? cnt_q : cpu_addr;
    assign wdata = in_init ? init_word : cpu_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rvalid  <= 1'b0;
            disp_rvalid <= 1'b0;
        end else begin
            cpu_rvalid  <= cpu_rd;
            disp_rvalid <= disp_rd;
        end
    end

`ifdef VMEM_DOUBLE_BUFFER_EN
    logic              front_q, cpu_sel_q, disp_sel_q;
    logic [DATA_W-1:0] c_rd [2];
    logic [DATA_W-1:0] d_rd [2];

    // Remember which bank fed each port so rdata holds across swaps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front_q    <= 1'b0;
            cpu_sel_q  <= 1'b0;
            disp_sel_q <= 1'b0;
        end else begin
            if (ready && frame_swap) begin
                front_q <= ~front_q;
            end
            if (cpu_rd) begin
                cpu_sel_q <= ~front_q;
            end
            if (disp_rd) begin
                disp_sel_q <= front_q;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic ID = 1'(b);
        logic back;
        assign back = ID ^ front_q;

        vmem_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk     (clk),
            .reset   (reset),
            .we      (in_init | (ready & cpu_we & back)),
            .waddr   (waddr),
            .wdata   (wdata),
            .re_a    (cpu_rd & back),
            .raddr_a (cpu_addr),
            .rdata_a (c_rd[b]),
            .re_b    (disp_rd & ~back),
            .raddr_b (disp_addr),
            .rdata_b (d_rd[b])
        );
    end

    assign cpu_rdata  = c_rd[cpu_sel_q];
    assign disp_rdata = d_rd[disp_sel_q];
    assign front_bank = front_q;
`else
    logic unused_swap;
    assign unused_swap = frame_swap;
    assign front_bank  = 1'b0;

    vmem_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .we      (in_init | (ready & cpu_we)),
        .waddr   (waddr),
        .wdata   (wdata),
        .re_a    (cpu_rd),
        .raddr_a (cpu_addr),
        .rdata_a (cpu_rdata),
        .re_b    (disp_rd),
        .raddr_b (disp_addr),
        .rdata_b (disp_rdata)
    );
`endif

endmodule

// File: tb/tb_vmem_dp.sv
// tb_vmem_dp: randomized and directed checks of vmem_dp against a
// behavioural memory model.
module tb_vmem_dp;

    localparam int DEPTH = 32;
`ifdef VMEM_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       init_req   = 1'b0;
    logic       cpu_we     = 1'b0;
    logic       cpu_re     = 1'b0;
    logic       disp_re    = 1'b0;
    logic       frame_swap = 1'b0;
    logic [4:0] cpu_addr   = '0;
    logic [4:0] disp_addr  = '0;
    logic [7:0] cpu_wdata  = '0;
    logic       init_busy, cpu_rvalid, disp_rvalid, front_bank;
    logic [7:0] cpu_rdata, disp_rdata;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] mem [2][DEPTH];
    int         init_left;
    logic       front;
    logic [7:0] e_crd, e_drd;
    logic       e_cv, e_dv;

    always #5 clk = ~clk;

    vmem_dp dut (
        .clk         (clk),
        .reset       (reset),
        .init_req    (init_req),
        .init_busy   (init_busy),
        .cpu_we      (cpu_we),
        .cpu_re      (cpu_re),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_rvalid  (cpu_rvalid),
        .disp_re     (disp_re),
        .disp_addr   (disp_addr),
        .disp_rdata  (disp_rdata),
        .disp_rvalid (disp_rvalid),
        .frame_swap  (frame_swap),
        .front_bank  (front_bank)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pre(input int a);
        return (a < 16) ? 8'hFF : 8'h00;
    endfunction

    task automatic model_reset();
        init_left = DEPTH;
        front     = 1'b0;
        e_crd     = '0;
        e_drd     = '0;
        e_cv      = 1'b0;
        e_dv      = 1'b0;
    endtask

    // One clock edge of the reference behaviour, using the current inputs.
    task automatic model_edge();
        int fb, bb;
        e_cv = 1'b0;
        e_dv = 1'b0;
        if (init_left > 0) begin
            int a;
            a = DEPTH - init_left;
            mem[0][a] = pre(a);
            mem[1][a] = pre(a);
            init_left--;
        end else begin
            fb = DB ? int'(front) : 0;
            bb = DB ? int'(!front) : 0;
            if (disp_re) begin
                e_drd = mem[fb][disp_addr];
                e_dv  = 1'b1;
            end
            if (cpu_re && !cpu_we) begin
                e_crd = mem[bb][cpu_addr];
                e_cv  = 1'b1;
            end
            if (cpu_we) mem[bb][cpu_addr] = cpu_wdata;
            if (DB && frame_swap) front = !front;
            if (init_req) init_left = DEPTH;
        end
    endtask

    task automatic check_outs();
        check("busy", 32'(init_busy), 32'(init_left > 0));
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(e_cv));
        check("cpu_rdata", 32'(cpu_rdata), 32'(e_crd));
        check("disp_rvalid", 32'(disp_rvalid), 32'(e_dv));
        check("disp_rdata", 32'(disp_rdata), 32'(e_drd));
        check("front_bank", 32'(front_bank), 32'(front));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
    endtask

    task automatic idle();
        init_req   = 1'b0;
        cpu_we     = 1'b0;
        cpu_re     = 1'b0;
        disp_re    = 1'b0;
        frame_swap = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        #2 reset = 1'b1;
        #1;
        check("rst_busy", 32'(init_busy), 32'd1);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("rst_disp_rdata", 32'(disp_rdata), 32'd0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_disp_rvalid", 32'(disp_rvalid), 32'd0);
        check("rst_front", 32'(front_bank), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
    endtask

    initial begin
        do_reset();

        for (int i = 0; i < DEPTH; i++) begin
            idle();
            if (i == 5) begin
                cpu_we    = 1'b1;
                cpu_addr  = 5'd3;
                cpu_wdata = 8'h5A;
            end else begin
                cpu_re    = 1'($urandom_range(0, 1));
                disp_re   = 1'($urandom_range(0, 1));
                cpu_addr  = 5'($urandom);
                disp_addr = 5'($urandom);
            end
            cycle();
        end
        idle();
        check("ready_at_32", 32'(init_busy), 32'd0);

        for (int a = 0; a < DEPTH; a++) begin
            idle();
            disp_re   = 1'b1;
            disp_addr = 5'(a);
            cycle();
            check("scan", 32'(disp_rdata), 32'(pre(a)));
        end

        idle();
        cpu_re   = 1'b1;
        cpu_addr = 5'd3;
        cycle();
        check("init_write_ignored", 32'(cpu_rdata), 32'hFF);

        idle();
        cpu_we    = 1'b1;
        cpu_addr  = 5'd20;
        cpu_wdata = 8'hA5;
        cycle();
        idle();
        cpu_re = 1'b1;
        cycle();
        check("wr_rd_valid", 32'(cpu_rvalid), 32'd1);
        check("wr_rd_data", 32'(cpu_rdata), 32'hA5);
        idle();
        cycle();
        check("rvalid_one_cycle", 32'(cpu_rvalid), 32'd0);

        idle();
        cpu_we    = 1'b1;
        cpu_addr  = 5'd7;
        cpu_wdata = 8'h3C;
        disp_re   = 1'b1;
        disp_addr = 5'd7;
        cycle();
        check("coll_old", 32'(disp_rdata), 32'hFF);
        idle();
        disp_re = 1'b1;
        cycle();
`ifdef VMEM_DOUBLE_BUFFER_EN
        check("coll_front_kept", 32'(disp_rdata), 32'hFF);
`else
        check("coll_new", 32'(disp_rdata), 32'h3C);
`endif

        idle();
        cpu_we    = 1'b1;
        cpu_re    = 1'b1;
        cpu_addr  = 5'd9;
        cpu_wdata = 8'h42;
        cycle();
        check("we_re_drop", 32'(cpu_rvalid), 32'd0);

        idle();
        cpu_we    = 1'b1;
        cpu_addr  = 5'd2;
        cpu_wdata = 8'h11;
        cycle();
        idle();
        init_req = 1'b1;
        cycle();
        check("reinit_busy", 32'(init_busy), 32'd1);
        idle();
        for (int i = 0; i < DEPTH; i++) cycle();
        check("reinit_done", 32'(init_busy), 32'd0);
        cpu_re   = 1'b1;
        cpu_addr = 5'd2;
        cycle();
        check("reinit_addr2", 32'(cpu_rdata), 32'hFF);

        idle();
        init_req = 1'b1;
        cycle();
        idle();
        for (int i = 0; i < 10; i++) cycle();
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle();
        check("rst_mid_done", 32'(init_busy), 32'd0);
        disp_re   = 1'b1;
        disp_addr = 5'd0;
        cycle();
        check("rst_mid_addr0", 32'(disp_rdata), 32'hFF);

`ifdef VMEM_DOUBLE_BUFFER_EN
        idle();
        cpu_we    = 1'b1;
        cpu_addr  = 5'd25;
        cpu_wdata = 8'h77;
        cycle();
        idle();
        disp_re   = 1'b1;
        disp_addr = 5'd25;
        cycle();
        check("db_front_old", 32'(disp_rdata), 32'h00);
        idle();
        frame_swap = 1'b1;
        cycle();
        check("db_swapped", 32'(front_bank), 32'd1);
        idle();
        disp_re = 1'b1;
        cycle();
        check("db_front_new", 32'(disp_rdata), 32'h77);
`endif

        for (int i = 0; i < 400; i++) begin
            idle();
            cpu_we     = ($urandom_range(0, 3) == 0);
            cpu_re     = 1'($urandom_range(0, 1));
            disp_re    = 1'($urandom_range(0, 1));
            cpu_addr   = 5'($urandom);
            disp_addr  = 5'($urandom);
            cpu_wdata  = 8'($urandom);
            init_req   = ($urandom_range(0, 79) == 0);
            frame_swap = ($urandom_range(0, 5) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
